// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with stall hold, branch flush bubbles,
//            multi-cycle squash of in-flight fetches and a stall watchdog.
//            Optional performance counters enabled by IF_ID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            IF_ID_writeEnable,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_insn,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_insn,
  output logic            stalled,
  output logic            stall_timeout
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_bubbles
`endif
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [1:0]  SQUASH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0]  STALL_LIMIT = 8'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        squash_cnt_q, squash_cnt_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic [31:0]       id_insn_q, id_insn_d;
  logic              timeout_q, timeout_d;
  logic              bubble_w;
  logic              hold_w;

  // Next-state decode: flush beats hold, hold beats squash, squash beats capture.
  always_comb begin
    state_d      = state_q;
    squash_cnt_d = squash_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_insn_d    = id_insn_q;
    timeout_d    = timeout_q;
    bubble_w     = 1'b0;
    hold_w       = 1'b0;
    if (flush) begin
      id_valid_d   = 1'b0;
      id_insn_d    = NOP;
      id_pc_d      = if_pc;
      squash_cnt_d = SQUASH_INIT;
      stall_cnt_d  = 8'd0;
      state_d      = (FLUSH_CYCLES > 1) ? SQUASH : RUN;
      bubble_w     = 1'b1;
    end else if (!IF_ID_writeEnable) begin
      // Pending squashes are kept so they resume once the stall releases.
      hold_w  = 1'b1;
      state_d = HOLD;
      if (stall_cnt_q == STALL_LIMIT) begin
        timeout_d = 1'b1;
      end
      if (stall_cnt_q != 8'hFF) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end else if (squash_cnt_q != 2'd0) begin
      // Only a real fetch consumes a squash slot; empty fetch slots are free.
      id_valid_d  = 1'b0;
      id_insn_d   = NOP;
      id_pc_d     = if_pc;
      stall_cnt_d = 8'd0;
      bubble_w    = 1'b1;
      if (if_valid) begin
        squash_cnt_d = squash_cnt_q - 2'd1;
      end
      state_d = (squash_cnt_d == 2'd0) ? RUN : SQUASH;
    end else begin
      id_valid_d  = if_valid;
      id_pc_d     = if_pc;
      id_insn_d   = if_valid ? if_insn : NOP;
      stall_cnt_d = 8'd0;
      state_d     = RUN;
    end
  end

  // Pipeline register, FSM state and watchdog, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      squash_cnt_q <= 2'd0;
      stall_cnt_q  <= 8'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_insn_q    <= NOP;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      squash_cnt_q <= squash_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_insn_q    <= id_insn_d;
      timeout_q    <= timeout_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign id_pc         = id_pc_q;
  assign id_insn       = id_insn_q;
  assign stalled       = (state_q == HOLD);
  assign stall_timeout = timeout_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bubble_q;

  // Saturating event counters for hold cycles and inserted bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q  <= 32'd0;
      perf_bubble_q <= 32'd0;
    end else begin
      if (hold_w && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (bubble_w && (perf_bubble_q != 32'hFFFF_FFFF)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_bubbles      = perf_bubble_q;
`else
  logic unused_w;
  assign unused_w = bubble_w ^ hold_w;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_reg
// Brief    : Self-checking bench for if_id_reg (FLUSH_CYCLES=2, MAX_STALL=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_reg;

  localparam int XLEN = 64;
  localparam int FLC  = 2;
  localparam int MAXS = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            we = 1'b1;
  logic            fl = 1'b0;
  logic            iv = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [31:0]     insn = '0;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_insn;
  logic            stalled;
  logic            stall_timeout;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;

  if_id_reg #(.XLEN(XLEN), .FLUSH_CYCLES(FLC), .MAX_STALL(MAXS)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IF_ID_writeEnable (we),
    .flush             (fl),
    .if_valid          (iv),
    .if_pc             (pc),
    .if_insn           (insn),
    .id_valid          (id_valid),
    .id_pc             (id_pc),
    .id_insn           (id_insn),
    .stalled           (stalled),
    .stall_timeout     (stall_timeout)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bubbles      (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we, fl, iv;
    logic [XLEN-1:0] pc;
    logic            ev;
    logic [XLEN-1:0] epc;
    logic [31:0]     einsn;
    logic            est, eto;
  } vec_t;

  function automatic logic [31:0] ins_of(input logic [XLEN-1:0] p);
    return 32'hA000_0000 | p[31:0];
  endfunction

  function automatic vec_t mk(input logic w, f, v, input logic [XLEN-1:0] p,
                              input logic ev, input logic [XLEN-1:0] epc,
                              input logic [31:0] ei, input logic est, eto);
    vec_t t;
    t.we = w; t.fl = f; t.iv = v; t.pc = p;
    t.ev = ev; t.epc = epc; t.einsn = ei; t.est = est; t.eto = eto;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [XLEN-1:0] epc,
                         input logic [31:0] ei, input logic est, input logic eto);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'(ev));
    chk({tag, ".id_pc"}, id_pc, epc);
    chk({tag, ".id_insn"}, 64'(id_insn), 64'(ei));
    chk({tag, ".stalled"}, 64'(stalled), 64'(est));
    chk({tag, ".stall_timeout"}, 64'(stall_timeout), 64'(eto));
  endtask

  // Reference model state (spec-level view of the register)
  int              m_pending;
  int              m_run;
  logic            m_valid, m_stalled, m_to;
  logic [XLEN-1:0] m_pc;
  logic [31:0]     m_insn;

  task automatic model_step(input logic w, f, v, input logic [XLEN-1:0] p,
                            input logic [31:0] i);
    if (f) begin
      m_valid = 1'b0; m_insn = NOP; m_pc = p;
      m_pending = FLC - 1; m_run = 0; m_stalled = 1'b0;
    end else if (!w) begin
      if (m_run == MAXS) m_to = 1'b1;
      m_run = (m_run < 255) ? m_run + 1 : 255;
      m_stalled = 1'b1;
    end else if (m_pending > 0) begin
      m_valid = 1'b0; m_insn = NOP; m_pc = p;
      if (v) m_pending = m_pending - 1;
      m_run = 0; m_stalled = 1'b0;
    end else begin
      m_valid = v; m_pc = p; m_insn = v ? i : NOP;
      m_run = 0; m_stalled = 1'b0;
    end
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = mk(1,0,1,64'h00, 1,64'h00,ins_of(64'h00),0,0);
    tbl[1]  = mk(1,0,1,64'h04, 1,64'h04,ins_of(64'h04),0,0);
    tbl[2]  = mk(0,0,1,64'h08, 1,64'h04,ins_of(64'h04),1,0);
    tbl[3]  = mk(0,0,1,64'h08, 1,64'h04,ins_of(64'h04),1,0);
    tbl[4]  = mk(0,0,1,64'h08, 1,64'h04,ins_of(64'h04),1,0);
    tbl[5]  = mk(1,0,1,64'h08, 1,64'h08,ins_of(64'h08),0,0);
    tbl[6]  = mk(1,1,1,64'h10, 0,64'h10,NOP,0,0);
    tbl[7]  = mk(1,0,1,64'h14, 0,64'h14,NOP,0,0);
    tbl[8]  = mk(1,0,1,64'h18, 1,64'h18,ins_of(64'h18),0,0);
    tbl[9]  = mk(0,1,1,64'h1C, 0,64'h1C,NOP,0,0);
    tbl[10] = mk(0,0,1,64'h20, 0,64'h1C,NOP,1,0);
    tbl[11] = mk(1,0,0,64'h20, 0,64'h20,NOP,0,0);
    tbl[12] = mk(1,0,1,64'h20, 0,64'h20,NOP,0,0);
    tbl[13] = mk(1,0,0,64'h24, 0,64'h24,NOP,0,0);
    tbl[14] = mk(1,0,1,64'h24, 1,64'h24,ins_of(64'h24),0,0);
    tbl[15] = mk(0,0,1,64'h28, 1,64'h24,ins_of(64'h24),1,0);
    tbl[16] = mk(0,0,1,64'h28, 1,64'h24,ins_of(64'h24),1,0);
    tbl[17] = mk(0,0,1,64'h28, 1,64'h24,ins_of(64'h24),1,0);
    tbl[18] = mk(0,0,1,64'h28, 1,64'h24,ins_of(64'h24),1,0);
    tbl[19] = mk(0,0,1,64'h28, 1,64'h24,ins_of(64'h24),1,1);
    tbl[20] = mk(1,0,1,64'h28, 1,64'h28,ins_of(64'h28),0,1);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, '0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    @(posedge clk); #1;
    for (int k = 0; k < 21; k++) begin
      we = tbl[k].we; fl = tbl[k].fl; iv = tbl[k].iv;
      pc = tbl[k].pc; insn = ins_of(tbl[k].pc);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", k), tbl[k].ev, tbl[k].epc, tbl[k].einsn,
              tbl[k].est, tbl[k].eto);
    end

    // Asynchronous reset in the middle of a squash window
    we = 1'b1; fl = 1'b1; iv = 1'b1; pc = 64'h30; insn = ins_of(64'h30);
    @(posedge clk); #1;
    chk("sqz.id_valid", 64'(id_valid), 64'd0);
    fl = 1'b0; pc = 64'h34; insn = ins_of(64'h34);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, '0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst", 1'b1, 64'h34, ins_of(64'h34), 1'b0, 1'b0);

    // Randomised traffic against the reference model
    m_pending = 0; m_run = 0; m_valid = 1'b1; m_stalled = 1'b0; m_to = 1'b0;
    m_pc = 64'h34; m_insn = ins_of(64'h34);
    for (int n = 0; n < 400; n++) begin
      int hold_pct;
      hold_pct = ((n / 40) % 2 == 1) ? 70 : 20;
      we   = ($urandom_range(99) >= hold_pct);
      fl   = ($urandom_range(99) < 8);
      iv   = ($urandom_range(99) < 80);
      pc   = {$urandom, $urandom} & ~64'h3;
      insn = $urandom;
      model_step(we, fl, iv, pc, insn);
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", n), m_valid, m_pc, m_insn, m_stalled, m_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
